// File: rtl/pma_region_table.sv
// Runtime-programmable PMA table: NrRules base/length/attr/lock entries behind a
// config port, looked up by NrPorts independent channels with one-deep response registers.
module pma_region_table #(
  parameter int unsigned                  AddrWidth   = 64,
  parameter int unsigned                  NrRules     = 8,
  parameter int unsigned                  NrPorts     = 2,
  parameter logic [NrRules*AddrWidth-1:0] RstBase     = (NrRules*AddrWidth)'(64'h8000_0000),
  parameter logic [NrRules*AddrWidth-1:0] RstLength   = (NrRules*AddrWidth)'(64'h4000_0000),
  parameter logic [NrRules*3-1:0]         RstAttr     = (NrRules*3)'(3'b011),
  parameter logic [2:0]                   DefaultAttr = 3'b100
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cfg_req_i,
  input  logic                         cfg_we_i,
  input  logic [3:0]                   cfg_idx_i,
  input  logic [1:0]                   cfg_field_i,
  input  logic [AddrWidth-1:0]         cfg_wdata_i,
  output logic                         cfg_rvalid_o,
  output logic [AddrWidth-1:0]         cfg_rdata_o,
  output logic                         cfg_err_o,
  input  logic [NrPorts-1:0]           lk_valid_i,
  output logic [NrPorts-1:0]           lk_ready_o,
  input  logic [NrPorts*AddrWidth-1:0] lk_addr_i,
  output logic [NrPorts-1:0]           rsp_valid_o,
  input  logic [NrPorts-1:0]           rsp_ready_i,
  output logic [NrPorts-1:0]           rsp_hit_o,
  output logic [NrPorts*4-1:0]         rsp_idx_o,
  output logic [NrPorts*3-1:0]         rsp_attr_o
);

  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] base_d [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [AddrWidth-1:0] len_d  [NrRules];
  logic [2:0]           attr_q [NrRules];
  logic [2:0]           attr_d [NrRules];
  logic [NrRules-1:0]   lock_q, lock_d;

  logic                 cfg_rvalid_q, cfg_rvalid_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [AddrWidth-1:0] cfg_rdata_q, cfg_rdata_d;
  logic                 in_range, sel_lock;
  logic [AddrWidth-1:0] sel_rdata;

  logic [NrPorts-1:0]   rsp_valid_q, rsp_valid_d;
  logic [NrPorts-1:0]   rsp_hit_q, rsp_hit_d;
  logic [NrPorts*4-1:0] rsp_idx_q, rsp_idx_d;
  logic [NrPorts*3-1:0] rsp_attr_q, rsp_attr_d;

  logic                 hit_c  [NrPorts];
  logic [3:0]           idx_c  [NrPorts];
  logic [2:0]           attr_c [NrPorts];

  // Limit compared in AddrWidth+1 bits so a region ending at 2^AddrWidth never wraps.
  function automatic logic rule_match(input logic [AddrWidth-1:0] a,
                                      input logic [AddrWidth-1:0] b,
                                      input logic [AddrWidth-1:0] l);
    return (l != '0) && ({1'b0, a} >= {1'b0, b}) && ({1'b0, a} < ({1'b0, b} + {1'b0, l}));
  endfunction

  always_comb begin
    for (int unsigned p = 0; p < NrPorts; p++) begin
      hit_c[p]  = 1'b0;
      idx_c[p]  = '0;
      attr_c[p] = DefaultAttr;
      for (int unsigned i = 0; i < NrRules; i++) begin
        if (!hit_c[p] && rule_match(lk_addr_i[p*AddrWidth +: AddrWidth], base_q[i], len_q[i])) begin
          hit_c[p]  = 1'b1;
          idx_c[p]  = 4'(i);
          attr_c[p] = attr_q[i];
        end
      end
    end
  end

  assign lk_ready_o = ~rsp_valid_q | rsp_ready_i;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_attr_d  = rsp_attr_q;
    for (int unsigned p = 0; p < NrPorts; p++) begin
      if (lk_ready_o[p]) begin
        rsp_valid_d[p] = lk_valid_i[p];
        if (lk_valid_i[p]) begin
          rsp_hit_d[p]        = hit_c[p];
          rsp_idx_d[p*4 +: 4]  = idx_c[p];
          rsp_attr_d[p*3 +: 3] = attr_c[p];
        end
      end
    end
  end

  always_comb begin
    base_d    = base_q;
    len_d     = len_q;
    attr_d    = attr_q;
    lock_d    = lock_q;
    sel_lock  = 1'b0;
    sel_rdata = '0;
    in_range  = 32'(cfg_idx_i) < NrRules;
    for (int unsigned i = 0; i < NrRules; i++) begin
      if (cfg_idx_i == 4'(i)) begin
        sel_lock = lock_q[i];
        case (cfg_field_i)
          2'd0:    sel_rdata = base_q[i];
          2'd1:    sel_rdata = len_q[i];
          2'd2:    sel_rdata = AddrWidth'(attr_q[i]);
          default: sel_rdata = AddrWidth'(lock_q[i]);
        endcase
        if (cfg_req_i && cfg_we_i && !lock_q[i]) begin
          case (cfg_field_i)
            2'd0:    base_d[i] = cfg_wdata_i;
            2'd1:    len_d[i]  = cfg_wdata_i;
            2'd2:    attr_d[i] = cfg_wdata_i[2:0];
            default: lock_d[i] = cfg_wdata_i[0];
          endcase
        end
      end
    end
    cfg_rvalid_d = cfg_req_i;
    cfg_err_d    = cfg_req_i && (!in_range || (cfg_we_i && sel_lock));
    cfg_rdata_d  = (cfg_req_i && !cfg_we_i && in_range) ? sel_rdata : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NrRules; i++) begin
        base_q[i] <= RstBase[i*AddrWidth +: AddrWidth];
        len_q[i]  <= RstLength[i*AddrWidth +: AddrWidth];
        attr_q[i] <= RstAttr[i*3 +: 3];
      end
      lock_q       <= '0;
      cfg_rvalid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_rdata_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_hit_q    <= '0;
      rsp_idx_q    <= '0;
      rsp_attr_q   <= '0;
    end else begin
      base_q       <= base_d;
      len_q        <= len_d;
      attr_q       <= attr_d;
      lock_q       <= lock_d;
      cfg_rvalid_q <= cfg_rvalid_d;
      cfg_err_q    <= cfg_err_d;
      cfg_rdata_q  <= cfg_rdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_idx_q    <= rsp_idx_d;
      rsp_attr_q   <= rsp_attr_d;
    end
  end

  assign cfg_rvalid_o = cfg_rvalid_q;
  assign cfg_err_o    = cfg_err_q;
  assign cfg_rdata_o  = cfg_rdata_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_hit_o    = rsp_hit_q;
  assign rsp_idx_o    = rsp_idx_q;
  assign rsp_attr_o   = rsp_attr_q;

endmodule

// File: tb/tb_pma_region_table.sv
// Bench for pma_region_table: directed vector table, hand-written corner sequences,
// then randomized traffic against an array-based reference model.
module tb_pma_region_table;
  localparam int AW = 64;
  localparam int NR = 8;
  localparam int NP = 2;

  typedef logic [7:0] rsp_t;  // {hit, idx[3:0], attr[2:0]}
  typedef struct {
    logic [63:0] addr;
    logic        hit;
    logic [3:0]  idx;
    logic [2:0]  attr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             cfg_req, cfg_we;
  logic [3:0]       cfg_idx;
  logic [1:0]       cfg_field;
  logic [AW-1:0]    cfg_wdata;
  logic             cfg_rvalid, cfg_err;
  logic [AW-1:0]    cfg_rdata;
  logic [NP-1:0]    lk_valid, lk_ready, rsp_valid, rsp_ready, rsp_hit;
  logic [NP*AW-1:0] lk_addr;
  logic [NP*4-1:0]  rsp_idx;
  logic [NP*3-1:0]  rsp_attr;

  pma_region_table #(.AddrWidth(AW), .NrRules(NR), .NrPorts(NP)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_field_i(cfg_field),
    .cfg_wdata_i(cfg_wdata), .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
    .lk_valid_i(lk_valid), .lk_ready_o(lk_ready), .lk_addr_i(lk_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_hit_o(rsp_hit),
    .rsp_idx_o(rsp_idx), .rsp_attr_o(rsp_attr)
  );

  int tests = 0;
  int fails = 0;

  logic [63:0] mb [NR];
  logic [63:0] ml [NR];
  logic [2:0]  ma [NR];
  logic        mk [NR];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic rsp_t dut_rsp(input int p);
    return {rsp_hit[p], rsp_idx[p*4 +: 4], rsp_attr[p*3 +: 3]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mb[i] = '0; ml[i] = '0; ma[i] = '0; mk[i] = 1'b0;
    end
    mb[0] = 64'h8000_0000; ml[0] = 64'h4000_0000; ma[0] = 3'b011;
  endtask

  // Scan high to low so the lowest matching rule is the one left standing.
  function automatic rsp_t ref_lookup(input logic [63:0] a);
    rsp_t r = {1'b0, 4'd0, 3'b100};
    for (int i = NR - 1; i >= 0; i--)
      if (ml[i] != 0 && a >= mb[i] && (a - mb[i]) < ml[i]) r = {1'b1, 4'(i), ma[i]};
    return r;
  endfunction

  task automatic model_cfg(input logic we, input logic [3:0] idx, input logic [1:0] fld,
                           input logic [63:0] wd, output logic err, output logic [63:0] rd);
    rd = '0;
    err = 1'b0;
    if (int'(idx) >= NR) err = 1'b1;
    else if (we) begin
      if (mk[idx]) err = 1'b1;
      else case (fld)
        2'd0: mb[idx] = wd;
        2'd1: ml[idx] = wd;
        2'd2: ma[idx] = wd[2:0];
        default: mk[idx] = wd[0];
      endcase
    end else case (fld)
      2'd0: rd = mb[idx];
      2'd1: rd = ml[idx];
      2'd2: rd = {61'd0, ma[idx]};
      default: rd = {63'd0, mk[idx]};
    endcase
  endtask

  task automatic cfg_drive(input logic we, input logic [3:0] idx, input logic [1:0] fld, input logic [63:0] wd);
    cfg_req = 1'b1; cfg_we = we; cfg_idx = idx; cfg_field = fld; cfg_wdata = wd;
  endtask

  task automatic cfg_chk(input string nm, input logic we, input logic [3:0] idx, input logic [1:0] fld,
                         input logic [63:0] wd, input logic exp_err, input logic [63:0] exp_rd);
    cfg_drive(we, idx, fld, wd);
    tick();
    cfg_req = 1'b0;
    chk({nm, "_rvalid"}, cfg_rvalid, 1'b1);
    chk({nm, "_err"}, cfg_err, exp_err);
    if (!we) chk({nm, "_rdata"}, cfg_rdata, exp_rd);
  endtask

  task automatic lk_chk(input string nm, input int p, input logic [63:0] a,
                        input logic h, input logic [3:0] ix, input logic [2:0] at);
    lk_valid[p] = 1'b1;
    lk_addr[p*AW +: AW] = a;
    tick();
    lk_valid = '0;
    chk(nm, {rsp_valid[p], dut_rsp(p)}, {1'b1, h, ix, at});
  endtask

  task automatic run_vecs(input vec_t v [16], input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      lk_chk($sformatf("vec%0d", i), i % 2, v[i].addr, v[i].hit, v[i].idx, v[i].attr);
  endtask

  initial begin
    vec_t  vecs [16];
    rsp_t  pval [NP];
    logic  pend [NP];
    logic  exp_rdy, ecv, ewe, eerr;
    logic [63:0] erd;

    vecs[0]  = '{64'h8000_1000, 1'b1, 4'd0, 3'b011};
    vecs[1]  = '{64'hC000_0000, 1'b0, 4'd0, 3'b100};
    vecs[2]  = '{64'h7FFF_FFFF, 1'b0, 4'd0, 3'b100};
    vecs[3]  = '{64'hBFFF_FFFF, 1'b1, 4'd0, 3'b011};
    vecs[4]  = '{64'h8000_0000, 1'b1, 4'd0, 3'b011};
    vecs[5]  = '{64'h0000_FFFF, 1'b0, 4'd0, 3'b100};
    vecs[6]  = '{64'h0001_0000, 1'b1, 4'd1, 3'b010};
    vecs[7]  = '{64'h0001_FFFF, 1'b1, 4'd1, 3'b010};
    vecs[8]  = '{64'h0002_0000, 1'b0, 4'd0, 3'b100};
    vecs[9]  = '{64'h0001_0000, 1'b1, 4'd0, 3'b011};
    vecs[10] = '{64'h0002_0000, 1'b0, 4'd0, 3'b100};
    vecs[11] = '{64'h0000_0000, 1'b1, 4'd0, 3'b011};
    vecs[12] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd2, 3'b001};
    vecs[13] = '{64'h0000_0000, 1'b0, 4'd0, 3'b100};
    vecs[14] = '{64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 4'd0, 3'b100};
    vecs[15] = '{64'hFFFF_FFFF_FFFF_F000, 1'b1, 4'd2, 3'b001};

    rst_n = 1'b0; cfg_req = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_wdata = '0;
    lk_valid = '0; lk_addr = '0; rsp_ready = '1;
    tick(); tick();
    chk("rst_rsp", {rsp_valid, rsp_hit, rsp_idx, rsp_attr}, '0);
    chk("rst_cfg", {cfg_rvalid, cfg_err}, 2'b00);
    chk("rst_rdata", cfg_rdata, '0);
    chk("rst_lk_ready", lk_ready, 2'b11);
    rst_n = 1'b1;
    tick();

    run_vecs(vecs, 0, 4);
    cfg_chk("wr_e1_base", 1'b1, 4'd1, 2'd0, 64'h1_0000, 1'b0, '0);
    cfg_chk("wr_e1_len",  1'b1, 4'd1, 2'd1, 64'h1_0000, 1'b0, '0);
    cfg_chk("wr_e1_attr", 1'b1, 4'd1, 2'd2, 64'hFFFF_FFF2, 1'b0, '0);
    cfg_chk("rd_e1_attr", 1'b0, 4'd1, 2'd2, '0, 1'b0, 64'h2);
    run_vecs(vecs, 5, 8);
    cfg_chk("wr_e0_base", 1'b1, 4'd0, 2'd0, 64'h0, 1'b0, '0);
    cfg_chk("wr_e0_len",  1'b1, 4'd0, 2'd1, 64'h2_0000, 1'b0, '0);
    run_vecs(vecs, 9, 11);
    cfg_chk("rst_e0_base", 1'b1, 4'd0, 2'd0, 64'h8000_0000, 1'b0, '0);
    cfg_chk("rst_e0_len",  1'b1, 4'd0, 2'd1, 64'h4000_0000, 1'b0, '0);
    cfg_chk("wr_e2_base", 1'b1, 4'd2, 2'd0, 64'hFFFF_FFFF_FFFF_F000, 1'b0, '0);
    cfg_chk("wr_e2_len",  1'b1, 4'd2, 2'd1, 64'h1000, 1'b0, '0);
    cfg_chk("wr_e2_attr", 1'b1, 4'd2, 2'd2, 64'h1, 1'b0, '0);
    run_vecs(vecs, 12, 15);

    cfg_chk("lock_set",    1'b1, 4'd0, 2'd3, 64'h1, 1'b0, '0);
    cfg_chk("locked_wr",   1'b1, 4'd0, 2'd0, 64'h0, 1'b1, '0);
    cfg_chk("locked_rd",   1'b0, 4'd0, 2'd0, '0, 1'b0, 64'h8000_0000);
    cfg_chk("lock_rd",     1'b0, 4'd0, 2'd3, '0, 1'b0, 64'h1);
    cfg_chk("unlock_wr",   1'b1, 4'd0, 2'd3, 64'h0, 1'b1, '0);
    lk_chk("locked_lk", 0, 64'h8000_1000, 1'b1, 4'd0, 3'b011);
    cfg_chk("oor_wr9",     1'b1, 4'd9, 2'd0, 64'h1234, 1'b1, '0);
    cfg_chk("oor_rd9",     1'b0, 4'd9, 2'd0, '0, 1'b1, 64'h0);
    cfg_chk("oor_rd8",     1'b0, 4'd8, 2'd2, '0, 1'b1, 64'h0);

    // Write and lookup in the same cycle: lookup sees the old attribute.
    cfg_drive(1'b1, 4'd1, 2'd2, 64'h5);
    lk_valid[0] = 1'b1; lk_addr[0 +: AW] = 64'h1_0000;
    tick();
    cfg_req = 1'b0; lk_valid = '0;
    chk("same_cyc_old", {rsp_valid[0], dut_rsp(0)}, {1'b1, 1'b1, 4'd1, 3'b010});
    chk("same_cyc_err", {cfg_rvalid, cfg_err}, 2'b10);
    lk_chk("next_cyc_new", 0, 64'h1_0000, 1'b1, 4'd1, 3'b101);

    // Port 1 stalled while entry1 is rewritten and port 0 streams lookups.
    rsp_ready = 2'b01;
    lk_valid[1] = 1'b1; lk_addr[AW +: AW] = 64'h1_8000;
    tick();
    lk_addr[AW +: AW] = 64'h8000_0000;
    for (int k = 0; k < 5; k++) begin
      cfg_drive(1'b1, 4'd1, 2'd2, 64'(k));
      lk_valid[0] = 1'b1; lk_addr[0 +: AW] = 64'h1_0000 + 64'(k);
      tick();
      chk("bp_p0", {rsp_valid[0], dut_rsp(0)}, {1'b1, 1'b1, 4'd1, (k == 0) ? 3'b101 : 3'(k - 1)});
      chk("bp_p1_hold", {rsp_valid[1], dut_rsp(1)}, {1'b1, 1'b1, 4'd1, 3'b101});
      chk("bp_p1_ready", lk_ready[1], 1'b0);
    end
    cfg_req = 1'b0; lk_valid = '0; rsp_ready = '1;
    #1;
    chk("bp_release_ready", lk_ready, 2'b11);
    tick();
    chk("bp_drain", rsp_valid, 2'b00);

    // Reset with a pending response and a config request in flight.
    lk_valid[0] = 1'b1; lk_addr[0 +: AW] = 64'h1_0000; rsp_ready = 2'b00;
    tick();
    lk_valid = '0;
    rst_n = 1'b0;
    cfg_drive(1'b0, 4'd0, 2'd0, '0);
    tick();
    chk("mid_rst_rsp", {rsp_valid, rsp_hit, rsp_idx, rsp_attr}, '0);
    chk("mid_rst_cfg", {cfg_rvalid, cfg_err}, 2'b00);
    chk("mid_rst_rdata", cfg_rdata, '0);
    chk("mid_rst_ready", lk_ready, 2'b11);
    rst_n = 1'b1; cfg_req = 1'b0; rsp_ready = '1;
    tick();
    chk("rst_req_dropped", cfg_rvalid, 1'b0);
    lk_chk("rst_e1_gone", 1, 64'h1_0000, 1'b0, 4'd0, 3'b100);
    lk_chk("rst_e0_back", 0, 64'h8000_1000, 1'b1, 4'd0, 3'b011);
    cfg_chk("rst_unlock", 1'b1, 4'd0, 2'd0, 64'h8000_0000, 1'b0, '0);

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int p = 0; p < NP; p++) begin pend[p] = 1'b0; pval[p] = '0; end
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < NP; p++) begin
        lk_valid[p]  = ($urandom % 4) != 0;
        rsp_ready[p] = ($urandom % 3) != 0;
        lk_addr[p*AW +: AW] = ($urandom % 8 == 0) ? 64'h8000_0000 + 64'($urandom_range(0, 15))
                                                  : 64'($urandom_range(0, 32'h1_A000));
      end
      cfg_req = ($urandom % 3) == 0;
      cfg_we = $urandom % 2;
      cfg_idx = 4'($urandom_range(0, 9));
      cfg_field = 2'($urandom % 4);
      if (cfg_field == 2'd3 && cfg_we && ($urandom % 6) != 0) cfg_field = 2'd2;
      case (cfg_field)
        2'd0: cfg_wdata = 64'($urandom_range(0, 24)) << 12;
        2'd1: cfg_wdata = 64'($urandom_range(0, 6)) << 12;
        default: cfg_wdata = {$urandom, $urandom};
      endcase
      #1;
      for (int p = 0; p < NP; p++) begin
        exp_rdy = !pend[p] || rsp_ready[p];
        chk("rnd_lk_ready", lk_ready[p], exp_rdy);
        if (exp_rdy) begin
          pend[p] = lk_valid[p];
          if (lk_valid[p]) pval[p] = ref_lookup(lk_addr[p*AW +: AW]);
        end
      end
      ecv = cfg_req; ewe = cfg_we; eerr = 1'b0; erd = '0;
      if (cfg_req) model_cfg(cfg_we, cfg_idx, cfg_field, cfg_wdata, eerr, erd);
      tick();
      for (int p = 0; p < NP; p++) begin
        chk("rnd_rsp_valid", rsp_valid[p], pend[p]);
        if (pend[p]) chk("rnd_rsp", dut_rsp(p), pval[p]);
      end
      chk("rnd_cfg_rvalid", cfg_rvalid, ecv);
      if (ecv) chk("rnd_cfg_err", cfg_err, eerr);
      if (ecv && !ewe) chk("rnd_cfg_rdata", cfg_rdata, erd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
